// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Brief    : Time-multiplexed FIR engine. Stores each accepted sample in a
//            circular delay line, sweeps the external coefficient ROM with a
//            single signed MAC, then presents one shifted, saturated output
//            sample on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int TAPS  = 32,
    parameter int AW    = 5,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int ACC_W = 40,
    parameter int SHIFT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_mac  = 2'd1;
    localparam logic [1:0] c_out  = 2'd2;

    localparam int PW = DW + CW;

    // Saturation limits expressed at accumulator width so the compare is signed.
    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [AW-1:0]           c_last_tap = AW'(TAPS - 1);

    logic [1:0]              r_state;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_newest;
    logic [AW-1:0]           r_tap;
    logic signed [ACC_W-1:0] r_acc;
    logic [DW-1:0]           r_buf [TAPS];
    logic [DW-1:0]           r_dout;
    logic                    r_dout_valid;

    logic                    w_accept;
    logic [AW-1:0]           w_rd_idx;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W-1:0] w_shifted;
    logic [DW-1:0]           w_sat;

    assign din_ready  = (r_state == c_idle);
    assign busy       = (r_state != c_idle);
    assign coef_addr  = (r_state == c_mac) ? r_tap : '0;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

    assign w_accept = (r_state == c_idle) && din_valid;

    // Walk backwards in time from the newest sample; index wraps mod TAPS.
    assign w_rd_idx   = r_newest - r_tap;
    assign w_prod     = $signed(r_buf[w_rd_idx]) * $signed(coef_data);
    assign w_acc_next = r_acc + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
    assign w_shifted  = w_acc_next >>> SHIFT;

    // Clamp the truncated result into the signed output range.
    always_comb begin
        w_sat = w_shifted[DW-1:0];
        if (w_shifted > c_sat_max) begin
            w_sat = c_sat_max[DW-1:0];
        end else if (w_shifted < c_sat_min) begin
            w_sat = c_sat_min[DW-1:0];
        end
    end

    // Delay line: written only on an accepted sample, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_accept) begin
            r_buf[r_wr_ptr] <= din;
        end
    end

    // Sequencer: accept sample, run TAPS MAC cycles, hold output until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_wr_ptr     <= '0;
            r_newest     <= '0;
            r_tap        <= '0;
            r_acc        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (din_valid) begin
                        r_newest <= r_wr_ptr;
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_tap    <= '0;
                        r_acc    <= '0;
                        r_state  <= c_mac;
                    end
                end
                c_mac: begin
                    r_acc <= w_acc_next;
                    r_tap <= r_tap + 1'b1;
                    if (r_tap == c_last_tap) begin
                        r_dout       <= w_sat;
                        r_dout_valid <= 1'b1;
                        r_state      <= c_out;
                    end
                end
                c_out: begin
                    if (dout_ready) begin
                        r_dout_valid <= 1'b0;
                        r_state      <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Brief    : Directed self-checking bench for fir_mac_sequencer with a
//            behavioural coefficient ROM (table or constant stub).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [4:0]  coef_addr;
    logic [15:0] coef_data;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;

    logic               rom_sel;
    logic [15:0]        rom_const;
    logic signed [15:0] prod_rom [32];

    int n_tests = 0;
    int n_fail  = 0;

    int coef_tab [32] = '{
           12,     16,    -33,     45,   -101,    250,   -377,    600,
        -1023,   1500,  -2207,   3300,  -5001,   7777, -12345,  20102,
       -20102,  12345,  -7777,   5001,  -3300,   2207,  -1500,   1023,
         -600,    377,   -250,    101,    -45,     33,    -16,    -12
    };

    fir_mac_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy)
    );

    // Combinational ROM, same-cycle response to coef_addr.
    assign coef_data = rom_sel ? rom_const : prod_rom[coef_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_sample(input logic [15:0] s);
        int n;
        n = 0;
        while (din_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        din       = s;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    // Called right after the accept edge; counts edges until dout_valid.
    task automatic wait_output(output logic signed [15:0] y, output int lat,
                               output logic addr_ok);
        lat     = 0;
        addr_ok = 1'b1;
        while (dout_valid !== 1'b1 && lat < 100) begin
            if (lat < 32 && coef_addr !== 5'(lat)) addr_ok = 1'b0;
            step();
            lat++;
        end
        y = dout;
        check("latency", lat, 32);
    endtask

    task automatic run_sample(input logic [15:0] s, output logic signed [15:0] y,
                              output logic addr_ok);
        int lat;
        start_sample(s);
        wait_output(y, lat, addr_ok);
        step();
    endtask

    initial begin
        logic signed [15:0] y;
        logic               ok;
        logic               flag;
        int                 lat;
        int                 exp;

        rst_n      = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        rom_sel    = 1'b0;
        rom_const  = '0;
        for (int i = 0; i < 32; i++) prod_rom[i] = 16'(coef_tab[i]);

        // Reset asserted mid-cycle takes effect without a clock edge.
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_dout", $signed(dout), 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_din_ready", din_ready, 1);
        check("rst_coef_addr", coef_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_din_ready", din_ready, 1);
        check("idle_coef_addr", coef_addr, 0);
        check("idle_busy", busy, 0);

        // Impulse through the coefficient table: output n = floor(coef[n]/2).
        for (int n = 0; n < 32; n++) begin
            run_sample((n == 0) ? 16'd16384 : 16'd0, y, ok);
            exp = prod_rom[n] >>> 1;
            check("imp_addr_sweep", ok, 1);
            check("imp_dout", $signed(y), exp);
            if (n == 1)  check("imp_dout_n1", $signed(y), 8);
            if (n == 15) check("imp_dout_n15", $signed(y), 10051);
            if (n == 16) check("imp_dout_n16", $signed(y), -10051);
        end

        // Saturation, positive then negative, with all-0x7FFF coefficients.
        apply_reset();
        rom_sel   = 1'b1;
        rom_const = 16'h7FFF;
        for (int n = 0; n < 32; n++) begin
            run_sample(16'h7FFF, y, ok);
            if (n == 0) check("sat_first", $signed(y), 32766);
        end
        check("sat_pos", $signed(y), 32767);
        for (int n = 0; n < 32; n++) run_sample(16'h8000, y, ok);
        check("sat_neg", $signed(y), -32768);

        // Backpressure: hold OUT for 10 cycles while a sample is offered.
        apply_reset();
        rom_const  = 16'h0400;
        dout_ready = 1'b0;
        start_sample(16'd1000);
        wait_output(y, lat, ok);
        check("bp_dout", $signed(y), 31);
        din       = 16'd2000;
        din_valid = 1'b1;
        flag      = 1'b1;
        repeat (10) begin
            step();
            if (dout !== y || dout_valid !== 1'b1 || din_ready !== 1'b0 || busy !== 1'b1)
                flag = 1'b0;
        end
        check("bp_stable", flag, 1);
        dout_ready = 1'b1;
        step();
        check("bp_release_valid", dout_valid, 0);
        check("bp_release_ready", din_ready, 1);
        check("bp_dout_kept", $signed(dout), 31);
        step();
        din_valid = 1'b0;
        check("bp_pending_busy", busy, 1);
        check("bp_pending_ready", din_ready, 0);
        wait_output(y, lat, ok);
        check("bp_second_dout", $signed(y), 93);
        step();

        // Reset at MAC tap 10 aborts the sample and clears history.
        start_sample(16'd3000);
        repeat (10) step();
        check("abort_tap", coef_addr, 10);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_dout", $signed(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        flag  = 1'b0;
        repeat (40) begin
            step();
            if (dout_valid !== 1'b0) flag = 1'b1;
        end
        check("abort_no_valid", flag, 0);
        run_sample(16'd1000, y, ok);
        check("abort_next_dout", $signed(y), 31);

        // Steady state across the write-pointer wrap.
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            run_sample(16'd1000, y, ok);
            exp = (((k < 32) ? k : 32) * 1000 * 1024) >>> 15;
            check("wrap_dout", $signed(y), exp);
            if (k == 2)  check("wrap_dout_k2", $signed(y), 62);
            if (k == 40) check("wrap_dout_k40", $signed(y), 1000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
